// File: rtl/configs_word_loader.sv
// Streams NUM_WORDS config words into flop storage over a valid/ready port, with start/abort/done control.
// Define CFG_PARITY_EN to add odd-parity checking per word (io_d_par in, sticky io_err out).
module configs_word_loader #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 40,
    parameter int PTR_W     = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        io_start,
    input  logic                        io_abort,
    input  logic [DATA_W-1:0]           io_d_in,
    input  logic                        io_d_valid,
`ifdef CFG_PARITY_EN
    input  logic                        io_d_par,
    output logic                        io_err,
`endif
    output logic                        io_d_ready,
    output logic                        io_busy,
    output logic                        io_done,
    output logic                        io_configs_valid,
    output logic [PTR_W-1:0]            io_word_cnt,
    output logic [DATA_W*NUM_WORDS-1:0] io_configs_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WORDS - 1);
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(NUM_WORDS);

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] ptr;
    logic [DATA_W-1:0] words [NUM_WORDS];
    logic             load_start;
    logic             accept;
    logic             word_ok;
    logic             err;

    // Ready is a pure state decode; abort suppresses any beat in the same cycle.
    assign io_d_ready = (state == LOAD);
    assign accept     = io_d_valid & io_d_ready & ~io_abort;

`ifdef CFG_PARITY_EN
    assign word_ok = ^{io_d_in, io_d_par};
    assign io_err  = err;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (load_start) begin
            err <= 1'b0;
        end else if (accept && !word_ok) begin
            err <= 1'b1;
        end
    end
`else
    assign word_ok = 1'b1;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_next = state;
        load_start = 1'b0;
        if (io_abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (io_start) begin
                        state_next = LOAD;
                        load_start = 1'b1;
                    end
                end
                LOAD: begin
                    if (accept && ptr == LAST_PTR) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rejected-parity word still consumes its slot so the pointer tracks the stream position.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (load_start) begin
            ptr <= '0;
        end else if (accept && ptr != FULL_PTR) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (reset) begin
                words[k] <= '0;
            end else if (accept && word_ok && ptr == PTR_W'(k)) begin
                words[k] <= io_d_in;
            end
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_out
        assign io_configs_out[DATA_W*g +: DATA_W] = words[g];
    end

    assign io_busy          = (state == LOAD);
    assign io_done          = (state == DONE);
    assign io_configs_valid = (state == DONE) & ~err;
    assign io_word_cnt      = ptr;

endmodule
